artyz7_button_enable_ctrl: RTL and testbench



---
 rtl/artyz7_button_enable_ctrl_if.sv | 22 ++
 rtl/artyz7_button_enable_ctrl.sv | 157 +++++++++++++++
 tb/tb_artyz7_button_enable_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/artyz7_button_enable_ctrl_if.sv
// Button/enable bundle between the board push-buttons and the LED enable logic.
// The master drives the raw buttons; the slave (the controller) returns the
// per-channel LED enables and the one-cycle press strobes.
interface artyz7_button_enable_ctrl_if #(
    parameter int num_channels = 2
);
    logic [num_channels-1:0] button;
    logic [num_channels-1:0] enable_led;
    logic [num_channels-1:0] press_strobe;

    modport master (
        output button,
        input  enable_led,
        input  press_strobe
    );

    modport slave (
        input  button,
        output enable_led,
        output press_strobe
    );
endinterface

// File: rtl/artyz7_button_enable_ctrl.sv
// Push-button enable controller for the Arty Z7 LED driver.
// Each raw button is synchronised, sampled once more, then debounced.
// Every accepted press steps that channel's mode OFF -> ON -> BLINK -> OFF.
// The LED enable is decoded from the mode and registered. In BLINK it follows
// a blink phase shared by all channels, so every blinking LED is in step.
module artyz7_button_enable_ctrl #(
    parameter int num_channels             = 2,
    parameter int debounce_cycles          = 125000,
    parameter int blink_half_period_cycles = 62500000
) (
    input  logic                             ext_clk,
    input  logic                             reset_n,
    artyz7_button_enable_ctrl_if.slave       bus
);

    localparam int DB_W = $clog2(debounce_cycles) + 1;
    localparam int BL_W = $clog2(blink_half_period_cycles) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(debounce_cycles - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(blink_half_period_cycles - 1);

    // Elaboration-time parameter sanity checks.
    if (num_channels < 1) begin : g_bad_num_channels
        $error("num_channels must be >= 1");
    end
    if (debounce_cycles < 1) begin : g_bad_debounce_cycles
        $error("debounce_cycles must be >= 1");
    end
    if (blink_half_period_cycles < 1) begin : g_bad_blink_half_period
        $error("blink_half_period_cycles must be >= 1");
    end

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2
    } mode_e;

    // Two-flop synchroniser, then one sample register that feeds the debouncer.
    // The sample stage puts the first debounce decision one edge after the
    // synchronised level is available, giving debounce_cycles+2 edges from the
    // first pin sample to the accepted level.
    logic [num_channels-1:0] sync1_q;
    logic [num_channels-1:0] sync2_q;
    logic [num_channels-1:0] level_q;

    logic [num_channels-1:0] debounced_q, debounced_d;
    logic [num_channels-1:0] strobe_q,    strobe_d;
    logic [num_channels-1:0] enable_q,    enable_d;
    logic [DB_W-1:0]         db_cnt_q [num_channels];
    logic [DB_W-1:0]         db_cnt_d [num_channels];
    mode_e                   mode_q   [num_channels];
    mode_e                   mode_d   [num_channels];

    logic [BL_W-1:0]         blink_cnt_q, blink_cnt_d;
    logic                    phase_q,     phase_d;

    // Synchroniser chain and debouncer sample register.
    always_ff @(posedge ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= {num_channels{1'b0}};
            sync2_q <= {num_channels{1'b0}};
            level_q <= {num_channels{1'b0}};
        end else begin
            sync1_q <= bus.button;
            sync2_q <= sync1_q;
            level_q <= sync2_q;
        end
    end

    // Debounce counters; a rising acceptance also raises the press strobe.
    always_comb begin
        debounced_d = debounced_q;
        strobe_d    = {num_channels{1'b0}};
        for (int i = 0; i < num_channels; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (level_q[i] == debounced_q[i]) begin
                db_cnt_d[i] = {DB_W{1'b0}};
            end else if (db_cnt_q[i] == DB_LAST) begin
                debounced_d[i] = level_q[i];
                db_cnt_d[i]    = {DB_W{1'b0}};
                strobe_d[i]    = level_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    // Mode next-state: each strobe advances that channel one step.
    always_comb begin
        for (int i = 0; i < num_channels; i++) begin
            mode_d[i] = mode_q[i];
            if (strobe_q[i]) begin
                case (mode_q[i])
                    MODE_OFF:   mode_d[i] = MODE_ON;
                    MODE_ON:    mode_d[i] = MODE_BLINK;
                    MODE_BLINK: mode_d[i] = MODE_OFF;
                    default:    mode_d[i] = MODE_OFF;
                endcase
            end else begin
                mode_d[i] = mode_q[i];
            end
        end
    end

    // Output decode from the registered mode, so the enable never glitches.
    always_comb begin
        enable_d = {num_channels{1'b0}};
        for (int i = 0; i < num_channels; i++) begin
            case (mode_q[i])
                MODE_OFF:   enable_d[i] = 1'b0;
                MODE_ON:    enable_d[i] = 1'b1;
                MODE_BLINK: enable_d[i] = phase_q;
                default:    enable_d[i] = 1'b0;
            endcase
        end
    end

    // Shared blink prescaler; runs in every mode to keep channels aligned.
    always_comb begin
        if (blink_cnt_q == BL_LAST) begin
            blink_cnt_d = {BL_W{1'b0}};
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BL_W'(1);
            phase_d     = phase_q;
        end
    end

    // State registers for debounce, mode, outputs and prescaler.
    always_ff @(posedge ext_clk or negedge reset_n) begin
        if (!reset_n) begin
            debounced_q <= {num_channels{1'b0}};
            strobe_q    <= {num_channels{1'b0}};
            enable_q    <= {num_channels{1'b0}};
            blink_cnt_q <= {BL_W{1'b0}};
            phase_q     <= 1'b0;
            for (int i = 0; i < num_channels; i++) begin
                db_cnt_q[i] <= {DB_W{1'b0}};
                mode_q[i]   <= MODE_OFF;
            end
        end else begin
            debounced_q <= debounced_d;
            strobe_q    <= strobe_d;
            enable_q    <= enable_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            for (int i = 0; i < num_channels; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
                mode_q[i]   <= mode_d[i];
            end
        end
    end

    assign bus.enable_led   = enable_q;
    assign bus.press_strobe = strobe_q;

endmodule

// File: tb/tb_artyz7_button_enable_ctrl.sv
// Directed bench for artyz7_button_enable_ctrl (2 channels, debounce 4, blink 8).
// Each press pushes its expected strobe and mode step into scoreboard queues.
// Every cycle the bench pops whatever is due and compares both outputs. The
// expected blink level comes from a prescaler count kept from reset release.
module tb_artyz7_button_enable_ctrl;

    localparam int NCH = 2;

    typedef struct {
        int         cyc;
        logic [1:0] strb;
    } sev_t;

    typedef struct {
        int cyc;
        int ch;
    } mev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = -1;
    int   passed = 0;
    int   total  = 0;
    int   exp_mode [NCH];
    sev_t sq [$];
    mev_t mq [$];

    artyz7_button_enable_ctrl_if #(.num_channels(NCH)) bus ();

    artyz7_button_enable_ctrl #(
        .num_channels            (NCH),
        .debounce_cycles         (4),
        .blink_half_period_cycles(8)
    ) dut (
        .ext_clk(clk),
        .reset_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Compare outputs against the scoreboard for the edge just taken.
    task automatic check_outputs();
        logic [1:0] es;
        logic [1:0] ee;
        es = 2'b00;
        if (sq.size() != 0 && sq[0].cyc == cyc) begin
            es = sq[0].strb;
            void'(sq.pop_front());
        end
        while (mq.size() != 0 && mq[0].cyc == cyc) begin
            exp_mode[mq[0].ch] = (exp_mode[mq[0].ch] + 1) % 3;
            void'(mq.pop_front());
        end
        for (int c = 0; c < NCH; c++) begin
            case (exp_mode[c])
                0:       ee[c] = 1'b0;
                1:       ee[c] = 1'b1;
                default: ee[c] = ((cyc / 8) % 2 == 1) ? 1'b1 : 1'b0;
            endcase
        end
        chk("press_strobe", {30'd0, bus.press_strobe}, {30'd0, es});
        chk("enable_led",   {30'd0, bus.enable_led},   {30'd0, ee});
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            check_outputs();
        end
    endtask

    // Called right after a new button level is driven (before edge cyc+1).
    task automatic expect_press(input logic [1:0] mask);
        sev_t s;
        mev_t m;
        s.cyc  = cyc + 7;
        s.strb = mask;
        sq.push_back(s);
        for (int c = 0; c < NCH; c++) begin
            if (mask[c]) begin
                m.cyc = cyc + 9;
                m.ch  = c;
                mq.push_back(m);
            end
        end
    endtask

    // Async reset between edges, checked without waiting for a clock edge.
    task automatic do_reset(input logic [1:0] btn, input string tag);
        #2;
        rst_n      = 1'b0;
        bus.button = btn;
        #1;
        chk({tag, "_async_en"},  {30'd0, bus.enable_led},   32'd0);
        chk({tag, "_async_stb"}, {30'd0, bus.press_strobe}, 32'd0);
        repeat (3) @(negedge clk);
        chk({tag, "_hold_en"},  {30'd0, bus.enable_led},   32'd0);
        chk({tag, "_hold_stb"}, {30'd0, bus.press_strobe}, 32'd0);
        chk({tag, "_sq_empty"}, sq.size(), 32'd0);
        chk({tag, "_mq_empty"}, mq.size(), 32'd0);
        sq.delete();
        mq.delete();
        #2;
        rst_n = 1'b1;
        cyc   = -1;
        for (int c = 0; c < NCH; c++) exp_mode[c] = 0;
    endtask

    task automatic press(input logic [1:0] mask, input int hold);
        bus.button = bus.button | mask;
        expect_press(mask);
        tick(hold);
        bus.button = bus.button & ~mask;
        tick(12);
    endtask

    initial begin
        bus.button = 2'b11;
        rst_n      = 1'b0;
        for (int c = 0; c < NCH; c++) exp_mode[c] = 0;

        // Buttons held through reset release: one press each, strobe edge 6, enable edge 8.
        do_reset(2'b11, "t1_reset");
        expect_press(2'b11);
        tick(12);
        bus.button = 2'b00;
        tick(12);

        // Bounce on ch0: 3-cycle pulses are rejected, the steady level is accepted.
        do_reset(2'b00, "t3_reset");
        tick(4);
        for (int b = 0; b < 2; b++) begin
            bus.button[0] = 1'b1;
            tick(3);
            bus.button[0] = 1'b0;
            tick(3);
        end
        bus.button[0] = 1'b1;
        expect_press(2'b01);
        tick(14);
        bus.button[0] = 1'b0;
        tick(12);

        // Clean 20-cycle press on ch0 (ON -> BLINK); release gives no strobe.
        press(2'b01, 20);

        // Full mode cycle on ch1 with a long look at the blink waveform.
        press(2'b10, 10);
        press(2'b10, 10);
        tick(40);
        press(2'b10, 10);
        tick(8);

        // Independence: ch0 ON and ch1 OFF pressed together.
        do_reset(2'b00, "t5_reset");
        tick(3);
        press(2'b01, 10);
        press(2'b11, 10);
        tick(4);

        // Reset mid-blink while ch0 is driving 1 from phase 1.
        for (int w = 0; w < 20 && (cyc % 16) != 10; w++) tick(1);
        chk("t6_phase_reached", cyc % 16, 32'd10);
        chk("t6_ch0_high_before_reset", {31'd0, bus.enable_led[0]}, 32'd1);
        do_reset(2'b00, "t6_reset");
        tick(30);

        chk("end_sq_empty", sq.size(), 32'd0);
        chk("end_mq_empty", mq.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
